// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for up to 32 bus drive requests. Its registered grant is always zero or one-hot.
// Optional hold limit is compiled in with `define BUS_TIMEOUT_EN.
module bus_source_arbiter #(
   parameter int N        = 32,
   parameter int PTR_W    = 5,
   parameter int MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         bus_busy,
   output logic         timeout
);

   // state   | meaning
   // IDLE    | no owner, grant is zero, arbitrate on any request
   // GRANTED | owner holds the bus while it keeps requesting
   typedef enum logic {IDLE, GRANTED} state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] owner, owner_nxt;
   logic [PTR_W-1:0] ptr, ptr_nxt;
   logic [N-1:0]     grant_nxt;
   logic             found;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] idx;
   logic             launch;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 1..255");
   end

   // Rotating search: ptr is tried first, then ptr+1, wrapping mod N.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr + PTR_W'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic       timeout_q, timeout_nxt;
   logic       expire;

   assign expire  = (state == GRANTED) && req[owner] && (hold_cnt == HOLD_LAST);
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      launch    = 1'b0;
`ifdef BUS_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
      timeout_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) launch = 1'b1;
            else       grant_nxt = '0;
         end
         GRANTED: begin
            if (req[owner]) begin
`ifdef BUS_TIMEOUT_EN
               if (expire) begin
                  grant_nxt   = '0;
                  state_nxt   = IDLE;
                  timeout_nxt = 1'b1;
               end else begin
                  hold_cnt_nxt = hold_cnt + 8'd1;
               end
`endif
            end else if (found) begin
               launch = 1'b1;
            end else begin
               grant_nxt = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
      if (launch) begin
         grant_nxt = {{(N-1){1'b0}}, 1'b1} << win;
         owner_nxt = win;
         ptr_nxt   = win + PTR_W'(1);
         state_nxt = GRANTED;
`ifdef BUS_TIMEOUT_EN
         hold_cnt_nxt = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         grant    <= '0;
         bus_busy <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         hold_cnt  <= 8'd0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         ptr      <= ptr_nxt;
         grant    <= grant_nxt;
         bus_busy <= |grant_nxt;
`ifdef BUS_TIMEOUT_EN
         hold_cnt  <= hold_cnt_nxt;
         timeout_q <= timeout_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: vector table plus hold-limit sequences.
module tb_bus_source_arbiter;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] req;
   logic [31:0] grant;
   logic        bus_busy;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   bus_source_arbiter #(.N(32), .PTR_W(5), .MAX_HOLD(4)) dut (
      .clk      (clk),
      .clr      (clr),
      .req      (req),
      .grant    (grant),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic [31:0] req;
      logic [31:0] grant;
      logic        tmo;
   } vec_t;

   typedef struct {
      logic [31:0] grant;
      logic        tmo;
      string       name;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[27];

   task automatic check_out();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got output %h want a queued expectation", grant);
         return;
      end
      e = sb.pop_front();
      if (grant !== e.grant) begin
         errors++;
         $display("FAIL %s grant got %h want %h", e.name, grant, e.grant);
      end
      checks++;
      if (bus_busy !== (|e.grant)) begin
         errors++;
         $display("FAIL %s bus_busy got %b want %b", e.name, bus_busy, |e.grant);
      end
      checks++;
      if (timeout !== e.tmo) begin
         errors++;
         $display("FAIL %s timeout got %b want %b", e.name, timeout, e.tmo);
      end
      checks++;
      if (!$onehot0(grant)) begin
         errors++;
         $display("FAIL %s onehot0 got %h want zero or one-hot", e.name, grant);
      end
   endtask

   task automatic step(input logic c, input logic [31:0] r, input logic [31:0] g,
                       input logic t, input string nm);
      exp_t e;
      @(negedge clk);
      clr = c;
      req = r;
      e.grant = g;
      e.tmo   = t;
      e.name  = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr = 1'b1;
      req = '0;

      // reset with all requests, then first grant to bit 0
      vecs[0]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      // rotation between bits 2 and 4
      vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0000_0004, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0000_0004, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0000_0010, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0000_0010, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0004, 32'h0000_0004, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0000_0004, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      // back-to-back handover 5 -> 8
      vecs[11] = '{1'b0, 32'h0000_0020, 32'h0000_0020, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      // pointer to 31, then wrap to 0
      vecs[15] = '{1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0};
      vecs[16] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[17] = '{1'b0, 32'h8000_0001, 32'h8000_0000, 1'b0};
      vecs[18] = '{1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0};
      vecs[19] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      // mid-grant reset restores ptr to 0
      vecs[20] = '{1'b0, 32'h0000_1000, 32'h0000_1000, 1'b0};
      vecs[21] = '{1'b0, 32'h0000_1000, 32'h0000_1000, 1'b0};
      vecs[22] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 1'b0};
      vecs[23] = '{1'b0, 32'h0000_1001, 32'h0000_0001, 1'b0};
      vecs[24] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[25] = '{1'b0, 32'h0000_1001, 32'h0000_1000, 1'b0};
      vecs[26] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};

      for (int i = 0; i < 27; i++)
         step(vecs[i].clr, vecs[i].req, vecs[i].grant, vecs[i].tmo, $sformatf("vec%0d", i));

      // release on the cycle the hold limit would be reached: plain handover
      step(1'b1, 32'h0, 32'h0, 1'b0, "vol_clr");
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, $sformatf("vol_hold%0d", i));
      step(1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0, "vol_handover");
      step(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, "vol_idle");

      step(1'b1, 32'h0, 32'h0, 1'b0, "hold_clr");
`ifdef BUS_TIMEOUT_EN
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0, $sformatf("to_a%0d", i));
      step(1'b0, 32'h0000_0003, 32'h0000_0000, 1'b1, "to_force_a");
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0000_0003, 32'h0000_0002, 1'b0, $sformatf("to_b%0d", i));
      step(1'b0, 32'h0000_0003, 32'h0000_0000, 1'b1, "to_force_b");
      step(1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0, "to_wrap_a");

      // sole requester is regranted after one idle cycle
      step(1'b1, 32'h0, 32'h0, 1'b0, "solo_clr");
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, $sformatf("solo_a%0d", i));
      step(1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, "solo_force");
      step(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, "solo_regrant");
`else
      for (int i = 0; i < 40; i++)
         step(1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0, $sformatf("nolimit%0d", i));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
